// File: rtl/ks_addsub_pipe_16b_pkg.sv
// Shared widths, depths, saturation limits and the stage record that travels
// down the Kogge-Stone adder/subtractor pipe.
package ks_addsub_pipe_16b_pkg;

    localparam int KS_W      = 16;
    localparam int KS_LEVELS = 4;
    localparam int KS_LAT    = 5;

    localparam logic [KS_W-1:0] KS_MAX = 16'h7FFF;
    localparam logic [KS_W-1:0] KS_MIN = 16'h8000;

    // g/p are the running prefix pair; p0, cin and a_msb ride along unchanged
    typedef struct packed {
        logic [KS_W-1:0] g;
        logic [KS_W-1:0] p;
        logic [KS_W-1:0] p0;
        logic            cin;
        logic            a_msb;
    } ks_stage_t;

    function automatic logic [KS_W-1:0] ks_clamp(input logic a_msb);
        logic [KS_W-1:0] res;
        if (a_msb) begin
            res = KS_MIN;
        end else begin
            res = KS_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/ks_addsub_pipe_16b_if.sv
// Operand/result stream between the butterfly datapath and the add/sub pipe.
interface ks_addsub_pipe_16b_if;
    import ks_addsub_pipe_16b_pkg::*;

    logic            i_valid;
    logic            o_ready;
    logic            i_sub;
    logic [KS_W-1:0] i_a;
    logic [KS_W-1:0] i_b;
    logic            o_valid;
    logic            i_ready;
    logic [KS_W-1:0] o_sum;
    logic            o_cout;
    logic            o_ovf;

    modport master (
        output i_valid, i_sub, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_ovf
    );

    modport slave (
        input  i_valid, i_sub, i_a, i_b, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_ovf
    );

endinterface

// File: rtl/ks_addsub_pipe_16b_prefix_lvl.sv
// Prefix cells and one registered Kogge-Stone level at a fixed distance.
module grey_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    output logic g_out
);
    assign g_out = g_hi | (p_hi & g_lo);
endmodule

module black_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);
    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;
endmodule

module ks_prefix_lvl_16b
    import ks_addsub_pipe_16b_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  ks_stage_t stage_in,
    output ks_stage_t stage_out
);

    logic [KS_W-1:0] g_nxt_s;
    logic [KS_W-1:0] p_nxt_s;
    ks_stage_t       stage_r;

    // Bit DIST-1 is the one that picks up cin here; lower bits are already final
    for (genvar i = 0; i < KS_W; i++) begin : g_bit
        if (i >= DIST) begin : g_black
            black_cell u_cell (
                .g_hi  (stage_in.g[i]),
                .p_hi  (stage_in.p[i]),
                .g_lo  (stage_in.g[i-DIST]),
                .p_lo  (stage_in.p[i-DIST]),
                .g_out (g_nxt_s[i]),
                .p_out (p_nxt_s[i])
            );
        end else if (i == DIST - 1) begin : g_grey
            grey_cell u_cell (
                .g_hi  (stage_in.g[i]),
                .p_hi  (stage_in.p[i]),
                .g_lo  (stage_in.cin),
                .g_out (g_nxt_s[i])
            );
            assign p_nxt_s[i] = stage_in.p[i];
        end else begin : g_pass
            assign g_nxt_s[i] = stage_in.g[i];
            assign p_nxt_s[i] = stage_in.p[i];
        end
    end

    // Level register, frozen while the pipe is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r <= '0;
        end else if (en) begin
            stage_r.g     <= g_nxt_s;
            stage_r.p     <= p_nxt_s;
            stage_r.p0    <= stage_in.p0;
            stage_r.cin   <= stage_in.cin;
            stage_r.a_msb <= stage_in.a_msb;
        end
    end

    assign stage_out = stage_r;

endmodule

// File: rtl/ks_addsub_pipe_16b.sv
// Pipelined 16-bit add/sub for the FFT butterfly: operand stage, four prefix
// levels and a result stage, all stalled together by downstream back-pressure.
module ks_addsub_pipe_16b
    import ks_addsub_pipe_16b_pkg::*;
#(
    parameter bit SAT_EN = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ks_addsub_pipe_16b_if.slave  bus
);

    logic               en_s;
    logic               accept_s;
    logic [KS_W-1:0]    b_eff_s;
    ks_stage_t          s0_r;
    ks_stage_t          pipe_s [0:KS_LEVELS];
    ks_stage_t          last_s;
    logic [KS_LEVELS:0] vld_r;
    logic [KS_W-1:0]    carry_s;
    logic [KS_W-1:0]    sum_raw_s;
    logic [KS_W-1:0]    sum_s;
    logic               cout_s;
    logic               ovf_s;
    logic               unused_p_s;

    assign en_s        = ~bus.o_valid | bus.i_ready;
    assign bus.o_ready = en_s;
    assign accept_s    = bus.i_valid & en_s;
    assign b_eff_s     = bus.i_b ^ {KS_W{bus.i_sub}};

    // Operand stage: bit-level generate/propagate with B inverted for subtract
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s0_r <= '0;
        end else if (accept_s) begin
            s0_r.g     <= bus.i_a & b_eff_s;
            s0_r.p     <= bus.i_a ^ b_eff_s;
            s0_r.p0    <= bus.i_a ^ b_eff_s;
            s0_r.cin   <= bus.i_sub;
            s0_r.a_msb <= bus.i_a[KS_W-1];
        end
    end

    assign pipe_s[0] = s0_r;

    for (genvar lv = 0; lv < KS_LEVELS; lv++) begin : g_lvl
        ks_prefix_lvl_16b #(
            .DIST (1 << lv)
        ) u_lvl (
            .clk       (i_clk),
            .rst       (i_rst),
            .en        (en_s),
            .stage_in  (pipe_s[lv]),
            .stage_out (pipe_s[lv+1])
        );
    end

    assign last_s     = pipe_s[KS_LEVELS];
    assign unused_p_s = ^last_s.p[KS_W-2:0];

    // Bit 15 spans 15:0 without cin after the last level, so one more grey
    // merge with cin is needed to form the carry out.
    always_comb begin
        carry_s   = {last_s.g[KS_W-2:0], last_s.cin};
        sum_raw_s = last_s.p0 ^ carry_s;
        cout_s    = last_s.g[KS_W-1] | (last_s.p[KS_W-1] & last_s.cin);
        ovf_s     = carry_s[KS_W-1] ^ cout_s;
        if (SAT_EN && ovf_s) begin
            sum_s = ks_clamp(last_s.a_msb);
        end else begin
            sum_s = sum_raw_s;
        end
    end

    // Valid shift chain and registered result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_r       <= '0;
            bus.o_valid <= 1'b0;
            bus.o_sum   <= '0;
            bus.o_cout  <= 1'b0;
            bus.o_ovf   <= 1'b0;
        end else if (en_s) begin
            vld_r       <= {vld_r[KS_LEVELS-1:0], bus.i_valid};
            bus.o_valid <= vld_r[KS_LEVELS];
            bus.o_sum   <= sum_s;
            bus.o_cout  <= cout_s;
            bus.o_ovf   <= ovf_s;
        end
    end

endmodule

// File: tb/tb_ks_addsub_pipe_16b.sv
// Directed bench for ks_addsub_pipe_16b: a wrapping and a saturating instance
// see identical stimulus and are checked against hand values and a small model.
module tb_ks_addsub_pipe_16b;
    import ks_addsub_pipe_16b_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    logic [15:0] st_a [0:7] = '{16'h0001, 16'h7FFF, 16'h8000, 16'h1234,
                                16'hFFFF, 16'h4000, 16'h8001, 16'h0000};
    logic [15:0] st_b [0:7] = '{16'h0002, 16'h0002, 16'h0001, 16'h1111,
                                16'hFFFF, 16'h4000, 16'h7FFF, 16'h8000};
    logic        st_s [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    ks_addsub_pipe_16b_if bus0 ();
    ks_addsub_pipe_16b_if bus1 ();

    assign bus1.i_valid = bus0.i_valid;
    assign bus1.i_sub   = bus0.i_sub;
    assign bus1.i_a     = bus0.i_a;
    assign bus1.i_b     = bus0.i_b;
    assign bus1.i_ready = bus0.i_ready;

    ks_addsub_pipe_16b #(.SAT_EN(1'b0)) u_dut_wrap (.i_clk(clk), .i_rst(rst), .bus(bus0));
    ks_addsub_pipe_16b #(.SAT_EN(1'b1)) u_dut_sat  (.i_clk(clk), .i_rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain 17-bit arithmetic
    function automatic logic [17:0] ref_op(input logic sub, input logic [15:0] a,
                                           input logic [15:0] b, input bit sat);
        logic [15:0] bb;
        logic [16:0] full;
        logic [15:0] s;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
        ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        s    = full[15:0];
        if (sat && ovf) s = a[15] ? 16'h8000 : 16'h7FFF;
        return {ovf, full[16], s};
    endfunction

    task automatic run_op(input string tag, input logic sub, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] e_wrap,
                          input logic [15:0] e_sat, input logic e_cout, input logic e_ovf);
        int cnt;
        @(negedge clk);
        bus0.i_valid = 1'b1;
        bus0.i_sub   = sub;
        bus0.i_a     = a;
        bus0.i_b     = b;
        @(negedge clk);
        bus0.i_valid = 1'b0;
        cnt = 0;
        while (!bus0.o_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_lat"},      16'(cnt), 16'(KS_LAT));
        chk({tag, "_sum_wrap"}, bus0.o_sum, e_wrap);
        chk({tag, "_sum_sat"},  bus1.o_sum, e_sat);
        chk({tag, "_cout"},     16'(bus0.o_cout), 16'(e_cout));
        chk({tag, "_ovf"},      16'(bus0.o_ovf), 16'(e_ovf));
        chk({tag, "_ovf_sat"},  16'(bus1.o_ovf), 16'(e_ovf));
    endtask

    initial begin
        int sent;
        int got;
        int stall_left;
        int stall_seen;
        int stale;
        bit stall_done;
        logic [17:0] ew;
        logic [17:0] es;

        bus0.i_valid = 1'b0;
        bus0.i_sub   = 1'b0;
        bus0.i_a     = 16'h0000;
        bus0.i_b     = 16'h0000;
        bus0.i_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid",     16'(bus0.o_valid), 16'd0);
        chk("rst_valid_sat", 16'(bus1.o_valid), 16'd0);
        chk("rst_sum",       bus0.o_sum, 16'h0000);
        chk("rst_cout",      16'(bus0.o_cout), 16'd0);
        chk("rst_ovf",       16'(bus0.o_ovf), 16'd0);
        chk("rst_ready",     16'(bus0.o_ready), 16'd1);
        rst = 1'b0;

        run_op("add_basic",  1'b0, 16'h1234, 16'h4321, 16'h5555, 16'h5555, 1'b0, 1'b0);
        run_op("sub_borrow", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        run_op("add_ovf",    1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
        run_op("sub_ovf",    1'b1, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
        run_op("add_negovf", 1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b1);
        run_op("sub_posovf", 1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 1'b1);

        // Back-to-back stream with a 3-cycle downstream stall after two results
        sent = 0; got = 0; stall_left = 0; stall_seen = 0; stall_done = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(negedge clk);
            if (got == 2 && !stall_done) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            bus0.i_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (sent < 8) begin
                bus0.i_valid = 1'b1;
                bus0.i_sub   = st_s[sent];
                bus0.i_a     = st_a[sent];
                bus0.i_b     = st_b[sent];
            end else begin
                bus0.i_valid = 1'b0;
            end
            #1;
            if (bus0.i_valid && bus0.o_ready) sent++;
            if (bus0.o_valid) begin
                ew = ref_op(st_s[got], st_a[got], st_b[got], 1'b0);
                es = ref_op(st_s[got], st_a[got], st_b[got], 1'b1);
                if (bus0.i_ready) begin
                    chk("stream_sum_wrap", bus0.o_sum, ew[15:0]);
                    chk("stream_sum_sat",  bus1.o_sum, es[15:0]);
                    chk("stream_cout",     16'(bus0.o_cout), 16'(ew[16]));
                    chk("stream_ovf",      16'(bus1.o_ovf), 16'(es[17]));
                    got++;
                end else begin
                    stall_seen++;
                    chk("stall_ready",    16'(bus0.o_ready), 16'd0);
                    chk("stall_hold_sum", bus1.o_sum, es[15:0]);
                    chk("stall_hold_ovf", 16'(bus0.o_ovf), 16'(ew[17]));
                end
            end
        end
        chk("stream_count", 16'(got), 16'd8);
        chk("stall_cycles", 16'(stall_seen), 16'd3);

        // Reset with three operations in flight and the first one parked at the output
        @(negedge clk);
        bus0.i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus0.i_valid = 1'b1;
            bus0.i_sub   = 1'b0;
            bus0.i_a     = 16'h1111 * 16'(k + 1);
            bus0.i_b     = 16'h0101;
            @(negedge clk);
        end
        bus0.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", 16'(bus0.o_valid), 16'd1);
        chk("pre_rst_sum",   bus0.o_sum, 16'h1212);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 16'(bus0.o_valid), 16'd0);
        chk("async_rst_sum",   bus0.o_sum, 16'h0000);
        chk("async_rst_ready", 16'(bus0.o_ready), 16'd1);
        chk("async_rst_sat",   16'(bus1.o_valid), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus0.i_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus0.o_valid || bus1.o_valid) stale++;
        end
        chk("no_stale", 16'(stale), 16'd0);
        run_op("post_rst", 1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 16'h1000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
